mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage controller directly downstream of the execute-stage byte-write-enable generator.
- Takes the registered M-stage memory request (4-bit byte write enable, address, raw store data, load type).
- Drives an SRAM-like data bus with an addr_ok/data_ok handshake and stalls the pipeline until the access completes.
- Returns the load result already sign- or zero-extended for writeback.
- Byte-lane convention: bit 3 of the write enable = address offset 0 = data[31:24].

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, present for documentation only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- memenM  input  1  M-stage instruction is a load or store.
- memwriteM  input  4  byte write enables; 0000 means load.
- aluoutM  input  32  effective address.
- writedataM  input  32  raw rt value for stores.
- loadtypeM  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others treated as LW.
- flushM  input  1  exception or flush of the current M instruction.
- data_req  output  1  bus request.
- data_wr  output  1  1 = write.
- data_size  output  2  00 byte, 01 half, 10 word.
- data_wstrb  output  4  byte strobes, equal to the latched memwriteM.
- data_addr  output  32  access address.
- data_wdata  output  32  lane-replicated store data.
- data_addr_ok  input  1  request accepted.
- data_data_ok  input  1  write done or read data valid.
- data_rdata  input  32  read data.
- stallM  output  1  hold the pipeline at M and earlier stages.
- readdataM  output  32  extended load result.

Behaviour:
- Reset (rst high on a clock edge):
  - state = IDLE.
  - data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, readdataM all 0.
  - stallM combinationally 0 in IDLE with memenM low.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If memenM=1 and flushM=0: latch request fields.
    - data_wr = |memwriteM.
    - data_size from popcount(memwriteM): 1→00, 2→01, 4→10. For loads, size comes from loadtypeM.
    - data_wdata: byte → {4{rt[7:0]}}, half → {2{rt[15:0]}}, word → rt.
    - Assert data_req next cycle; go to ADDR.
  - stallM is combinationally 1 in this cycle, so the pipeline never advances an un-issued access.
  - memenM=1 with flushM=1: no request, stallM=0, stay IDLE.
- ADDR:
  - data_req=1, all bus fields stable.
  - On data_addr_ok: drop data_req next cycle, go to DATA.
  - If data_data_ok arrives in the same cycle as data_addr_ok: go directly to DONE and capture data.
  - stallM=1.
- DATA:
  - data_req=0, stallM=1.
  - On data_data_ok: capture extended data_rdata into readdataM, go to DONE.
- DONE:
  - stallM=0, readdataM valid; the pipeline advances this cycle.
  - memenM may still be high for the same instruction and must not reissue.
  - Next state always IDLE.
- Load extension, using the latched address offset a = addr[1:0]:
  - Byte = data_rdata[31-8a -: 8].
  - Half: a=00 → [31:16], a=10 → [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - For a store, readdataM = 0.
- flushM asserted in ADDR/DATA/DONE is ignored: the transaction completes and the bus protocol is never violated.
- Misaligned combinations (memwriteM=0000 and memenM with an illegal half offset) are filtered upstream; the block issues them as given.
- Latency:
  - Minimum access is 3 cycles from request entry to stallM release: IDLE→ADDR→DATA/DONE.
  - Bus wait states extend ADDR and DATA without bound.
- rst mid-transaction: immediate return to IDLE with outputs zeroed. Any outstanding bus response is dropped by the bus wrapper, which is reset by the same rst.
- Back-to-back memory instructions: the second is sampled in IDLE on the cycle after DONE.

Test Plan:
- Reset: hold rst 2 cycles mid-ADDR → data_req=0, stallM=0, readdataM=0, state IDLE.
- SB store:
  - Stimulus: memwriteM=0100, aluoutM=0x1001, writedataM=0x12345678, addr_ok/data_ok each 1 cycle late.
  - Response: data_wr=1, data_size=00, data_wstrb=0100, data_wdata=0x78787878, data_addr=0x1001, stallM high until DONE.
- LB negative: aluoutM=0x2003, loadtype LB, data_rdata=0x112233F0 → readdataM=0xFFFFFFF0; same with LBU → 0x000000F0.
- LH at offset 2: data_rdata=0x8000ABCD → LH readdataM=0xFFFFABCD; LHU → 0x0000ABCD. Offset 0 LH on 0x8001_0000 → 0xFFFF8001.
- Same-cycle addr_ok and data_ok:
  - LW with both asserted in the first ADDR cycle → DONE next cycle, readdataM = data_rdata.
  - Exactly one request accepted even with memenM held high through DONE.
- flushM behaviour: flushM=1 in IDLE → no data_req, stallM=0. flushM raised during DATA → transaction finishes normally, no second request.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one SRAM-like bus transaction per M-stage
// memory instruction, stalls the pipeline until it completes, and returns extended load data.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memenM,
  input  logic [3:0]        memwriteM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedataM,
  input  logic [2:0]        loadtypeM,
  input  logic              flushM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              stallM,
  output logic [DATA_W-1:0] readdataM
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  state_t              state, state_next;
  logic                issue, capture;
  logic [1:0]          req_size;
  logic [DATA_W-1:0]   req_wdata;
  logic [2:0]          ltype_q;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;
  logic [DATA_W-1:0]   load_ext;

  // Bus request decode: stores size themselves from the strobe count, loads from the load type.
  always_comb begin
    req_size  = 2'b10;
    req_wdata = writedataM;
    if (|memwriteM) begin
      case (memwriteM)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 2'b00;
        4'b0011, 4'b1100:                   req_size = 2'b01;
        default:                            req_size = 2'b10;
      endcase
    end else begin
      case (loadtypeM)
        LT_LB, LT_LBU: req_size = 2'b00;
        LT_LH, LT_LHU: req_size = 2'b01;
        default:       req_size = 2'b10;
      endcase
    end
    case (req_size)
      2'b00:   req_wdata = {4{writedataM[7:0]}};
      2'b01:   req_wdata = {2{writedataM[15:0]}};
      default: req_wdata = writedataM;
    endcase
  end

  always_comb begin
    state_next = state;
    stallM     = 1'b0;
    data_req   = 1'b0;
    issue      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (memenM && !flushM) begin
          issue      = 1'b1;
          stallM     = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: begin
        data_req = 1'b1;
        stallM   = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            capture    = 1'b1;
            state_next = DONE;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        stallM = 1'b1;
        if (data_data_ok) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Big-endian lane order: offset 0 is the most significant byte of the bus word.
  always_comb begin
    case (data_addr[1:0])
      2'b00:   load_byte = data_rdata[31:24];
      2'b01:   load_byte = data_rdata[23:16];
      2'b10:   load_byte = data_rdata[15:8];
      default: load_byte = data_rdata[7:0];
    endcase
    load_half = data_addr[1] ? data_rdata[15:0] : data_rdata[31:16];
    case (ltype_q)
      LT_LB:   load_ext = {{24{load_byte[7]}}, load_byte};
      LT_LBU:  load_ext = {24'h000000, load_byte};
      LT_LH:   load_ext = {{16{load_half[15]}}, load_half};
      LT_LHU:  load_ext = {16'h0000, load_half};
      default: load_ext = data_rdata;
    endcase
    if (data_wr)
      load_ext = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_wr    <= 1'b0;
      data_size  <= 2'b00;
      data_wstrb <= 4'b0000;
      data_addr  <= '0;
      data_wdata <= '0;
      ltype_q    <= 3'b000;
      readdataM  <= '0;
    end else begin
      state <= state_next;
      if (issue) begin
        data_wr    <= |memwriteM;
        data_size  <= req_size;
        data_wstrb <= memwriteM;
        data_addr  <= aluoutM;
        data_wdata <= req_wdata;
        ltype_q    <= loadtypeM;
      end
      if (capture)
        readdataM <= load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized accesses
// checked against a lane/extension reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM;
  logic [3:0]  memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [2:0]  loadtypeM;
  logic        flushM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        stallM;
  logic [31:0] readdataM;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the most recent access
  logic        obs_wr;
  logic [1:0]  obs_size;
  logic [3:0]  obs_strb;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [31:0] obs_res;
  logic        obs_entry_stall;
  bit          obs_timeout;
  bit          obs_stable;
  int          obs_lat;
  int          obs_accepts;
  int          obs_extra;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM), .aluoutM(aluoutM),
    .writedataM(writedataM), .loadtypeM(loadtypeM), .flushM(flushM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .stallM(stallM), .readdataM(readdataM)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] m_size(logic [3:0] wen, logic [2:0] lt);
    if (wen != 4'b0000) begin
      case ($countones(wen))
        1: return 2'b00;
        2: return 2'b01;
        default: return 2'b10;
      endcase
    end
    if (lt == 3'd1 || lt == 3'd2) return 2'b00;
    if (lt == 3'd3 || lt == 3'd4) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] sz, logic [31:0] wd);
    logic [31:0] b;
    if (sz == 2'b00) begin
      b = wd & 32'h000000FF;
      return b * 32'h01010101;
    end
    if (sz == 2'b01) begin
      b = wd & 32'h0000FFFF;
      return b * 32'h00010001;
    end
    return wd;
  endfunction

  function automatic logic [31:0] m_load(logic [3:0] wen, logic [2:0] lt, logic [1:0] a, logic [31:0] rd);
    logic [31:0] v;
    int ai;
    ai = int'(a);
    if (wen != 4'b0000) return 32'h0;
    if (lt == 3'd1 || lt == 3'd2) begin
      v = (rd >> (8 * (3 - ai))) & 32'h000000FF;
      if (lt == 3'd1 && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (lt == 3'd3 || lt == 3'd4) begin
      v = (ai >= 2) ? (rd & 32'h0000FFFF) : (rd >> 16);
      if (lt == 3'd3 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Drives one access and plays the bus side; records what the DUT did.
  task automatic do_access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] lt, input int alat, input int dlat, input bit same,
                           input logic [31:0] rd, input bit flush_in_data, input int idle_after);
    bit done, seen, pend;
    int req_n, dw;
    done = 0; seen = 0; pend = 0; req_n = 0; dw = 0;
    obs_timeout = 0; obs_accepts = 0; obs_extra = 0; obs_stable = 1; obs_lat = 0; obs_res = 'x;
    @(negedge clk);
    memenM = 1'b1; memwriteM = wen; aluoutM = addr; writedataM = wd; loadtypeM = lt;
    flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
    #1 obs_entry_stall = stallM;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      if (data_req) begin
        if (!seen) begin
          seen = 1;
          obs_wr = data_wr; obs_size = data_size; obs_strb = data_wstrb;
          obs_addr = data_addr; obs_wdata = data_wdata;
        end else if ({data_wr, data_size, data_wstrb, data_addr, data_wdata} !==
                     {obs_wr, obs_size, obs_strb, obs_addr, obs_wdata}) begin
          obs_stable = 0;
        end
        if (req_n == alat) begin
          data_addr_ok = 1'b1;
          obs_accepts++;
          if (same) begin
            data_data_ok = 1'b1; data_rdata = rd;
          end else begin
            pend = 1; dw = 0;
          end
        end
        req_n++;
      end else if (pend) begin
        if (flush_in_data) flushM = 1'b1;
        if (dw == dlat) begin
          data_data_ok = 1'b1; data_rdata = rd; pend = 0;
        end
        dw++;
      end
      #1;
      if (!stallM) begin
        done = 1; obs_lat = cyc; obs_res = readdataM;
      end
    end
    if (!done) obs_timeout = 1;
    for (int i = 0; i < idle_after; i++) begin
      @(negedge clk);
      memenM = 1'b0; flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1 if (data_req) obs_extra++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; memenM = 1'b0; memwriteM = 4'b0; aluoutM = 32'h0; writedataM = 32'h0;
    loadtypeM = 3'b0; flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({data_req, stallM, data_wr, data_size, data_wstrb} !== 9'b0) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {data_req, stallM, data_wr, data_size, data_wstrb});
    end
    n_tests++;
    if ({data_addr, data_wdata, readdataM} !== 96'h0) begin
      n_fail++; $display("[TB] FAIL reset_data: got %h %h %h expected 0", data_addr, data_wdata, readdataM);
    end
  endtask

  task automatic test_sb_store;
    do_access(4'b0100, 32'h1001, 32'h12345678, 3'd0, 1, 1, 0, 32'hDEADBEEF, 0, 3);
    n_tests++;
    if (obs_entry_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_entry_stall: got %b expected 1", obs_entry_stall); end
    n_tests++;
    if ({obs_wr, obs_size, obs_strb} !== {1'b1, 2'b00, 4'b0100}) begin
      n_fail++; $display("[TB] FAIL sb_ctrl: got wr=%b size=%b strb=%b expected 1 00 0100", obs_wr, obs_size, obs_strb);
    end
    n_tests++;
    if (obs_wdata !== 32'h78787878) begin n_fail++; $display("[TB] FAIL sb_wdata: got %h expected 78787878", obs_wdata); end
    n_tests++;
    if (obs_addr !== 32'h1001) begin n_fail++; $display("[TB] FAIL sb_addr: got %h expected 00001001", obs_addr); end
    n_tests++;
    if (obs_timeout || obs_lat != 5) begin n_fail++; $display("[TB] FAIL sb_latency: got %0d (timeout=%0d) expected 5", obs_lat, obs_timeout); end
    n_tests++;
    if (obs_res !== 32'h0) begin n_fail++; $display("[TB] FAIL sb_readdata: got %h expected 0", obs_res); end
    n_tests++;
    if (obs_extra != 0 || !obs_stable) begin n_fail++; $display("[TB] FAIL sb_bus_proto: extra=%0d stable=%0d expected 0 1", obs_extra, obs_stable); end
  endtask

  task automatic test_lb_lbu;
    do_access(4'b0000, 32'h2003, 32'h0, 3'd1, 0, 0, 0, 32'h112233F0, 0, 1);
    n_tests++;
    if (obs_res !== 32'hFFFFFFF0 || obs_lat != 3) begin n_fail++; $display("[TB] FAIL lb: got %h lat %0d expected FFFFFFF0 lat 3", obs_res, obs_lat); end
    n_tests++;
    if ({obs_wr, obs_size} !== 3'b000) begin n_fail++; $display("[TB] FAIL lb_ctrl: got %b expected 000", {obs_wr, obs_size}); end
    do_access(4'b0000, 32'h2003, 32'h0, 3'd2, 0, 0, 0, 32'h112233F0, 0, 1);
    n_tests++;
    if (obs_res !== 32'h000000F0) begin n_fail++; $display("[TB] FAIL lbu: got %h expected 000000F0", obs_res); end
  endtask

  task automatic test_lh_lhu;
    do_access(4'b0000, 32'h4002, 32'h0, 3'd3, 2, 1, 0, 32'h8000ABCD, 0, 1);
    n_tests++;
    if (obs_res !== 32'hFFFFABCD) begin n_fail++; $display("[TB] FAIL lh_off2: got %h expected FFFFABCD", obs_res); end
    n_tests++;
    if (obs_size !== 2'b01) begin n_fail++; $display("[TB] FAIL lh_size: got %b expected 01", obs_size); end
    do_access(4'b0000, 32'h4002, 32'h0, 3'd4, 0, 2, 0, 32'h8000ABCD, 0, 1);
    n_tests++;
    if (obs_res !== 32'h0000ABCD) begin n_fail++; $display("[TB] FAIL lhu_off2: got %h expected 0000ABCD", obs_res); end
    do_access(4'b0000, 32'h4000, 32'h0, 3'd3, 0, 0, 0, 32'h80010000, 0, 1);
    n_tests++;
    if (obs_res !== 32'hFFFF8001) begin n_fail++; $display("[TB] FAIL lh_off0: got %h expected FFFF8001", obs_res); end
  endtask

  task automatic test_same_cycle;
    do_access(4'b0000, 32'h5000, 32'h0, 3'd0, 0, 0, 1, 32'hCAFEF00D, 0, 4);
    n_tests++;
    if (obs_timeout || obs_lat != 2) begin n_fail++; $display("[TB] FAIL same_latency: got %0d expected 2", obs_lat); end
    n_tests++;
    if (obs_res !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL same_data: got %h expected CAFEF00D", obs_res); end
    n_tests++;
    if (obs_accepts != 1 || obs_extra != 0) begin n_fail++; $display("[TB] FAIL same_single_req: accepts=%0d extra=%0d expected 1 0", obs_accepts, obs_extra); end
  endtask

  task automatic test_flush;
    int bad_req, bad_stall;
    bad_req = 0; bad_stall = 0;
    @(negedge clk);
    memenM = 1'b1; memwriteM = 4'b1111; aluoutM = 32'h6000; writedataM = 32'h1; flushM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stallM) bad_stall++;
      @(negedge clk);
      #1 if (data_req) bad_req++;
    end
    n_tests++;
    if (bad_stall != 0 || bad_req != 0) begin n_fail++; $display("[TB] FAIL flush_idle: stall=%0d req=%0d expected 0 0", bad_stall, bad_req); end
    memenM = 1'b0; flushM = 1'b0;
    do_access(4'b0000, 32'h6001, 32'h0, 3'd2, 1, 2, 0, 32'h00AB0000, 1, 3);
    n_tests++;
    if (obs_res !== 32'h000000AB || obs_lat != 6) begin n_fail++; $display("[TB] FAIL flush_data: got %h lat %0d expected 000000AB lat 6", obs_res, obs_lat); end
    n_tests++;
    if (obs_extra != 0) begin n_fail++; $display("[TB] FAIL flush_data_extra: got %0d expected 0", obs_extra); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    memenM = 1'b1; memwriteM = 4'b0; aluoutM = 32'h3000; loadtypeM = 3'd0; flushM = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (data_req !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_pre_req: got %b expected 1", data_req); end
    rst = 1'b1; memenM = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({data_req, stallM} !== 2'b00 || readdataM !== 32'h0 || data_addr !== 32'h0) begin
      n_fail++; $display("[TB] FAIL rstmid: got req=%b stall=%b rd=%h addr=%h expected all 0", data_req, stallM, readdataM, data_addr);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (data_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_idle: got %b expected 0", data_req); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res_a;
    do_access(4'b0000, 32'h7000, 32'h0, 3'd0, 0, 1, 0, 32'h01020304, 0, 0);
    res_a = obs_res;
    do_access(4'b0011, 32'h7002, 32'h0000BEEF, 3'd0, 0, 0, 0, 32'h0, 0, 2);
    n_tests++;
    if (res_a !== 32'h01020304) begin n_fail++; $display("[TB] FAIL b2b_first: got %h expected 01020304", res_a); end
    n_tests++;
    if (obs_entry_stall !== 1'b1 || obs_lat != 3 || obs_wdata !== 32'hBEEFBEEF || obs_strb !== 4'b0011) begin
      n_fail++; $display("[TB] FAIL b2b_second: stall=%b lat=%0d wdata=%h strb=%b expected 1 3 BEEFBEEF 0011", obs_entry_stall, obs_lat, obs_wdata, obs_strb);
    end
  endtask

  task automatic test_random;
    logic [3:0]  wen;
    logic [2:0]  lt;
    logic [1:0]  off, sz;
    logic [31:0] addr, wd, rd;
    int alat, dlat, exp_lat;
    bit same;
    for (int it = 0; it < 40; it++) begin
      lt = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0: begin off = 2'($urandom_range(0, 3)); wen = 4'b1000 >> off; end
          1: begin off = 2'($urandom_range(0, 1) * 2); wen = (off == 2'd0) ? 4'b1100 : 4'b0011; end
          default: begin off = 2'd0; wen = 4'b1111; end
        endcase
      end else begin
        wen = 4'b0000;
        if (lt == 3'd1 || lt == 3'd2) off = 2'($urandom_range(0, 3));
        else if (lt == 3'd3 || lt == 3'd4) off = 2'($urandom_range(0, 1) * 2);
        else off = 2'd0;
      end
      addr = ($urandom & 32'hFFFFFFFC) | {30'd0, off};
      wd = $urandom; rd = $urandom;
      alat = $urandom_range(0, 3); dlat = $urandom_range(0, 3); same = ($urandom_range(0, 3) == 0);
      exp_lat = same ? 2 + alat : 3 + alat + dlat;
      sz = m_size(wen, lt);
      do_access(wen, addr, wd, lt, alat, dlat, same, rd, 0, 2);
      n_tests++;
      if (obs_timeout || obs_lat != exp_lat || obs_entry_stall !== 1'b1) begin
        n_fail++; $display("[TB] FAIL rnd_timing[%0d]: lat=%0d entry_stall=%b expected lat=%0d stall=1", it, obs_lat, obs_entry_stall, exp_lat);
      end
      n_tests++;
      if ({obs_wr, obs_size, obs_strb, obs_addr} !== {(wen != 4'b0), sz, wen, addr}) begin
        n_fail++; $display("[TB] FAIL rnd_bus[%0d]: got wr=%b sz=%b strb=%b addr=%h expected %b %b %b %h",
                           it, obs_wr, obs_size, obs_strb, obs_addr, (wen != 4'b0), sz, wen, addr);
      end
      if (wen != 4'b0000) begin
        n_tests++;
        if (obs_wdata !== m_wdata(sz, wd)) begin n_fail++; $display("[TB] FAIL rnd_wdata[%0d]: got %h expected %h", it, obs_wdata, m_wdata(sz, wd)); end
      end
      n_tests++;
      if (obs_res !== m_load(wen, lt, off, rd)) begin
        n_fail++; $display("[TB] FAIL rnd_readdata[%0d]: lt=%0d off=%0d got %h expected %h", it, lt, off, obs_res, m_load(wen, lt, off, rd));
      end
      n_tests++;
      if (obs_accepts != 1 || obs_extra != 0 || !obs_stable) begin
        n_fail++; $display("[TB] FAIL rnd_proto[%0d]: accepts=%0d extra=%0d stable=%0d expected 1 0 1", it, obs_accepts, obs_extra, obs_stable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sb_store();
    test_lb_lbu();
    test_lh_lhu();
    test_reset_mid();
    test_same_cycle();
    test_flush();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
